serial_adder: RTL

SERIAL_ADDER -- requirements
Module: serial_adder

---
 rtl/serial_adder_pkg.sv | 22 ++
 rtl/full_adder.sv | 26 ++
 rtl/serial_adder.sv | 112 +++++++++++
 3 files changed

// File: rtl/serial_adder_pkg.sv
`default_nettype none
// ============================================================================
// Module      : serial_adder_pkg
// Description : FSM state encoding and sizing helper shared by serial_adder
//               and its testbench.
// Revision    : 1.0 - initial release
// ============================================================================
package serial_adder_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Bit counter width: one spare bit above clog2 so WIDTH itself is representable.
    function automatic int cnt_width(input int width);
        return $clog2(width) + 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/full_adder.sv
`default_nettype none
// ============================================================================
// Module      : full_adder
// Description : One-bit full adder built from two half adders and an OR.
// Revision    : 1.0 - initial release
// ============================================================================
module full_adder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic cout
);

    logic w_p;
    logic w_g;
    logic w_pc;

    assign w_p  = a ^ b;
    assign w_g  = a & b;
    assign s    = w_p ^ cin;
    assign w_pc = w_p & cin;
    assign cout = w_g | w_pc;

endmodule
`default_nettype wire

// File: rtl/serial_adder.sv
`default_nettype none
// ============================================================================
// Module      : serial_adder
// Description : Bit-serial add/subtract, one bit per clock, LSB first, with
//               unsigned carry and signed overflow flags.
// Revision    : 1.0 - initial release
// ============================================================================
module serial_adder
    import serial_adder_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_start,
    input  logic             i_sub,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    output logic             o_busy,
    output logic             o_done,
    output logic [WIDTH-1:0] o_sum,
    output logic             o_carry,
    output logic             o_overflow
);

    localparam int                 c_cnt_w = cnt_width(WIDTH);
    localparam logic [c_cnt_w-1:0] c_last  = c_cnt_w'(WIDTH - 1);

    state_t             r_state;
    state_t             w_next;
    logic [WIDTH-1:0]   r_a;
    logic [WIDTH-1:0]   r_b;
    logic [WIDTH-1:0]   r_acc;
    logic [WIDTH-1:0]   r_sum;
    logic               r_carry;
    logic               r_co;
    logic               r_ov;
    logic [c_cnt_w-1:0] r_cnt;
    logic               w_s;
    logic               w_cout;
    logic               w_last;
    logic               w_accept;

    full_adder u_fa (
        .a    (r_a[0]),
        .b    (r_b[0]),
        .cin  (r_carry),
        .s    (w_s),
        .cout (w_cout)
    );

    assign w_last   = (r_cnt == c_last);
    assign w_accept = (r_state == IDLE) && i_start;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (i_start) w_next = RUN;
            RUN:     if (w_last)  w_next = DONE;
            DONE:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_a     <= '0;
            r_b     <= '0;
            r_acc   <= '0;
            r_sum   <= '0;
            r_carry <= 1'b0;
            r_co    <= 1'b0;
            r_ov    <= 1'b0;
            r_cnt   <= '0;
        end else if (w_accept) begin
            // Subtraction is A + ~B + 1: invert B here and seed the carry with 1.
            r_a     <= i_a;
            r_b     <= i_sub ? ~i_b : i_b;
            r_carry <= i_sub;
            r_acc   <= '0;
            r_cnt   <= '0;
        end else if (r_state == RUN) begin
            r_acc   <= {w_s, r_acc[WIDTH-1:1]};
            r_a     <= r_a >> 1;
            r_b     <= r_b >> 1;
            r_carry <= w_cout;
            r_cnt   <= r_cnt + c_cnt_w'(1);
            if (w_last) begin
                // r_carry still holds the carry into the MSB on this final step.
                r_sum <= {w_s, r_acc[WIDTH-1:1]};
                r_co  <= w_cout;
                r_ov  <= r_carry ^ w_cout;
            end
        end
    end

    assign o_busy     = (r_state == RUN);
    assign o_done     = (r_state == DONE);
    assign o_sum      = r_sum;
    assign o_carry    = r_co;
    assign o_overflow = r_ov;

endmodule
`default_nettype wire
